ysyx_22050854_writeback_unit: RTL
=================================

Name: ysyx_22050854_writeback_unit

Overview:
- Producer side of the register-file write port. Collects completed results from the EXU (single-cycle ALU path) and the LSU (multi-cycle load path).
- Arbitrates the two sources onto the single write port and drives registered wen/waddr/wdata into the register file.
- Keeps a 32-entry busy scoreboard so issue logic can stall on RAW hazards.
- Counts committed results for difftest.

Parameters:
- XLEN, 64, data width of results and write port
- NREG, 32, architectural register count; address width is log2(NREG) = 5

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  instruction with destination issued this cycle
- issue_rd  in  5  destination of issued instruction
- exu_valid  in  1  EXU result valid
- exu_ready  out  1  EXU result accepted when exu_valid && exu_ready
- exu_rd  in  5  EXU destination
- exu_data  in  XLEN  EXU result
- lsu_valid  in  1  LSU load result valid
- lsu_ready  out  1  LSU result accepted; tied 1
- lsu_rd  in  5  LSU destination
- lsu_data  in  XLEN  LSU result
- rf_wen  out  1  register-file write enable (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wdata  out  XLEN  register-file write data (registered)
- busy_vec  out  NREG  bit i = register i has a pending write (registered)
- commit_cnt  out  64  number of accepted results since reset
- fwd_addr1, fwd_addr2  in  5  forwarding lookup addresses (see optional feature)
- fwd_hit1, fwd_hit2  out  1  forwarding hit
- fwd_data1, fwd_data2  out  XLEN  forwarded data

Behaviour:
- Reset (rst_n low, asynchronous):
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - busy_vec=0, commit_cnt=0.
  - Skid buffer empty; any in-flight result is dropped.
- One-entry EXU skid buffer (skid_v, skid_rd, skid_data).
  - exu_ready = !skid_v; it is combinational from state only, never from exu_valid.
- Write selection each cycle, priority LSU > skid > direct EXU:
  - LSU fires: LSU result is written. If the EXU also fires with the skid empty, the EXU result goes into the skid. If the skid is already full, it is held.
  - No LSU and skid_v: skid is written and skid_v clears; exu_ready was 0, so no EXU accept this cycle.
  - Only EXU fires: EXU result is written directly.
  - Nothing to write: rf_wen=0 next cycle.
- Latency: a result accepted or selected at edge N appears on rf_wen/waddr/wdata during cycle N+1. The register file commits it at edge N+2.
- rd==0: the handshake is accepted and commit_cnt increments, but rf_wen stays 0 for that slot. busy bit 0 is never set.
- Scoreboard:
  - Set bit issue_rd when issue_valid && issue_rd!=0.
  - Clear bit rf_waddr at the edge where rf_wen=1, i.e. the same edge the register file writes.
  - Set and clear of the same bit in the same cycle: set wins.
- WAW: issue_valid for a register whose busy bit is set is illegal. The simulation assertion fires (ifndef SYNTHESIS).
- commit_cnt: +1 per accepted EXU or LSU result; +2 when both are accepted in the same cycle. Wraps modulo 2^64.
- No ordering guarantee between EXU and LSU results beyond the priority rules above; in-order semantics are the issue stage's responsibility.

Optional Feature:
- YSYX_22050854_WB_FORWARD_EN defined:
  - fwd_hitK = rf_wen && rf_waddr==fwd_addrK && fwd_addrK!=0.
  - fwd_dataK = rf_wdata when hit, else 0.
  - Both are combinational, covering the cycle before the register file holds the value.
- Not defined: fwd_hit1/2=0 and fwd_data1/2=0 constant. Inputs are ignored, and issue must stall on busy_vec until the clear edge.

Decomposition:
- Shared package (ysyx_22050854_pkg):
  - XLEN, NREG, REG_AW=5 constants.
  - wb_src_e enum {WB_NONE, WB_LSU, WB_SKID, WB_EXU}.
  - wb_req_t struct {rd, data}.
- Sub-module ysyx_22050854_wb_scoreboard: busy vector set/clear logic and the WAW assertion.
- Arbitration, skid and counter stay in the top.

Test Plan:
- Basic EXU write: exu_valid with rd=5, data=0x1234 at edge 1 -> rf_wen=1, waddr=5, wdata=0x1234 in cycle 2; commit_cnt=1; exu_ready stays 1.
- Collision: EXU rd=3/0xAA and LSU rd=7/0xBB in the same cycle:
  - cycle N+1 writes 7/0xBB and exu_ready=0;
  - cycle N+2 writes 3/0xAA and exu_ready=1;
  - commit_cnt +2.
- Scoreboard: issue rd=9 -> busy_vec[9]=1. LSU result rd=9 accepted at edge N -> busy_vec[9] clears at edge N+2. Issue rd=9 on that same edge -> bit stays 1.
- x0 handling: EXU rd=0, data=0xFFFF -> rf_wen stays 0, commit_cnt increments, busy_vec unchanged.
- Reset mid-operation: skid full (rd=4) and rst_n pulsed low asynchronously -> all outputs 0 immediately, exu_ready=1 after release, and rd=4 is never written.
- Forwarding (macro on): rf_wen=1, waddr=12, wdata=0x55, fwd_addr1=12 -> fwd_hit1=1, fwd_data1=0x55. With fwd_addr1=0 -> fwd_hit1=0. Macro off -> always 0.

Source files
------------

// File: rtl/ysyx_22050854_pkg.sv
// Shared constants and types for the ysyx_22050854 writeback path.
package ysyx_22050854_pkg;

  localparam int XLEN   = 64;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_LSU  = 2'd1,
    WB_SKID = 2'd2,
    WB_EXU  = 2'd3
  } wb_src_e;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/ysyx_22050854_wb_scoreboard.sv
// Busy scoreboard: a bit is set on issue and cleared on the register-file write edge.
module ysyx_22050854_wb_scoreboard
  import ysyx_22050854_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              clr_valid,
  input  logic [REG_AW-1:0] clr_rd,
  output logic [NREG-1:0]   busy_vec
);

  logic [NREG-1:0] busy_r;
  logic [NREG-1:0] set_mask_s;
  logic [NREG-1:0] clr_mask_s;
  logic [NREG-1:0] busy_nxt_s;

  // Set/clear masks; a same-cycle set overrides the clear
  always_comb begin
    set_mask_s = {NREG{1'b0}};
    clr_mask_s = {NREG{1'b0}};
    if (issue_valid && (issue_rd != {REG_AW{1'b0}})) begin
      set_mask_s[issue_rd] = 1'b1;
    end else begin
      set_mask_s = {NREG{1'b0}};
    end
    if (clr_valid) begin
      clr_mask_s[clr_rd] = 1'b1;
    end else begin
      clr_mask_s = {NREG{1'b0}};
    end
    busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;
  end

  // Busy vector register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= {NREG{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign busy_vec = busy_r;

`ifndef SYNTHESIS
  // Re-issuing a register on the very edge its pending write retires is legal
  always @(posedge clk) begin
    if (rst_n && issue_valid && (issue_rd != {REG_AW{1'b0}})) begin
      assert (!busy_r[issue_rd] || (clr_valid && (clr_rd == issue_rd)))
        else $error("WAW issue to busy register x%0d", issue_rd);
    end
  end
`endif

endmodule

// File: rtl/ysyx_22050854_writeback_unit.sv
// Writeback arbiter: LSU > skid > EXU onto one registered RF write port, plus busy scoreboard.
// Optional combinational forwarding from the write port: define YSYX_22050854_WB_FORWARD_EN.
module ysyx_22050854_writeback_unit
  import ysyx_22050854_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              exu_valid,
  output logic              exu_ready,
  input  logic [REG_AW-1:0] exu_rd,
  input  logic [XLEN-1:0]   exu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic [NREG-1:0]   busy_vec,
  output logic [63:0]       commit_cnt,
  input  logic [REG_AW-1:0] fwd_addr1,
  input  logic [REG_AW-1:0] fwd_addr2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [XLEN-1:0]   fwd_data1,
  output logic [XLEN-1:0]   fwd_data2
);

  logic              skid_v_r;
  wb_req_t           skid_req_r;
  logic              rf_wen_r;
  logic [REG_AW-1:0] rf_waddr_r;
  logic [XLEN-1:0]   rf_wdata_r;
  logic [63:0]       commit_cnt_r;

  logic              exu_fire_s;
  logic              lsu_fire_s;
  logic [1:0]        cnt_inc_s;
  wb_src_e           sel_s;
  wb_req_t           sel_req_s;
  logic              skid_v_nxt_s;
  wb_req_t           skid_req_nxt_s;

  assign exu_ready  = !skid_v_r;
  assign lsu_ready  = 1'b1;
  assign exu_fire_s = exu_valid && exu_ready;
  assign lsu_fire_s = lsu_valid;
  assign cnt_inc_s  = {1'b0, exu_fire_s} + {1'b0, lsu_fire_s};

  // Source selection and skid next state
  always_comb begin
    sel_s          = WB_NONE;
    sel_req_s      = '{rd: {REG_AW{1'b0}}, data: {XLEN{1'b0}}};
    skid_v_nxt_s   = skid_v_r;
    skid_req_nxt_s = skid_req_r;
    if (lsu_fire_s) begin
      sel_s     = WB_LSU;
      sel_req_s = '{rd: lsu_rd, data: lsu_data};
      if (exu_fire_s) begin
        skid_v_nxt_s   = 1'b1;
        skid_req_nxt_s = '{rd: exu_rd, data: exu_data};
      end else begin
        skid_v_nxt_s   = skid_v_r;
      end
    end else if (skid_v_r) begin
      sel_s        = WB_SKID;
      sel_req_s    = skid_req_r;
      skid_v_nxt_s = 1'b0;
    end else if (exu_fire_s) begin
      sel_s     = WB_EXU;
      sel_req_s = '{rd: exu_rd, data: exu_data};
    end else begin
      sel_s = WB_NONE;
    end
  end

  // Skid, write port and commit counter registers; x0 results retire without a write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_v_r     <= 1'b0;
      skid_req_r   <= '{rd: {REG_AW{1'b0}}, data: {XLEN{1'b0}}};
      rf_wen_r     <= 1'b0;
      rf_waddr_r   <= {REG_AW{1'b0}};
      rf_wdata_r   <= {XLEN{1'b0}};
      commit_cnt_r <= 64'd0;
    end else begin
      skid_v_r     <= skid_v_nxt_s;
      skid_req_r   <= skid_req_nxt_s;
      rf_wen_r     <= (sel_s != WB_NONE) && (sel_req_s.rd != {REG_AW{1'b0}});
      if (sel_s != WB_NONE) begin
        rf_waddr_r <= sel_req_s.rd;
        rf_wdata_r <= sel_req_s.data;
      end else begin
        rf_waddr_r <= rf_waddr_r;
        rf_wdata_r <= rf_wdata_r;
      end
      commit_cnt_r <= commit_cnt_r + {62'd0, cnt_inc_s};
    end
  end

  assign rf_wen     = rf_wen_r;
  assign rf_waddr   = rf_waddr_r;
  assign rf_wdata   = rf_wdata_r;
  assign commit_cnt = commit_cnt_r;

  ysyx_22050854_wb_scoreboard u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .clr_valid   (rf_wen_r),
    .clr_rd      (rf_waddr_r),
    .busy_vec    (busy_vec)
  );

`ifdef YSYX_22050854_WB_FORWARD_EN
  assign fwd_hit1  = rf_wen_r && (rf_waddr_r == fwd_addr1) && (fwd_addr1 != {REG_AW{1'b0}});
  assign fwd_hit2  = rf_wen_r && (rf_waddr_r == fwd_addr2) && (fwd_addr2 != {REG_AW{1'b0}});
  assign fwd_data1 = fwd_hit1 ? rf_wdata_r : {XLEN{1'b0}};
  assign fwd_data2 = fwd_hit2 ? rf_wdata_r : {XLEN{1'b0}};
`else
  logic unused_fwd_s;
  assign unused_fwd_s = ^{fwd_addr1, fwd_addr2};
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = {XLEN{1'b0}};
  assign fwd_data2 = {XLEN{1'b0}};
`endif

endmodule
